cprv_dmem_arbiter: RTL and testbench

CPRV_DMEM_ARBITER -- requirements
Module: cprv_dmem_arbiter

---
 rtl/cprv_dmem_arbiter_if.sv | 65 ++++++
 rtl/cprv_dmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_cprv_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cprv_dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cprv_dmem_arbiter_if
//   Bundles every handshake and bus signal of the data-memory arbiter: the
//   fetch requester (if), the mem-stage requester (dm) and the shared memory
//   port (mem). Signal suffixes are written from the arbiter's point of view.
//
//   Modports:
//     slave  - the arbiter itself (takes requests, drives the memory port)
//     master - the surrounding system / testbench (drives requests, models
//              the memory)
//
//   Parameter:
//     DATA_WIDTH - address and data width of every port (default 64)
// -----------------------------------------------------------------------------
interface cprv_dmem_arbiter_if #(
    parameter int DATA_WIDTH = 64
) ();

    // Fetch requester (always a read)
    logic                  valid_if_i;
    logic                  ready_if_o;
    logic [DATA_WIDTH-1:0] addr_if_i;
    logic                  valid_if_rsp_o;
    logic                  ready_if_rsp_i;
    logic [DATA_WIDTH-1:0] rdata_if_o;

    // Mem-stage requester (load or store; stores also get a response)
    logic                  valid_dm_i;
    logic                  ready_dm_o;
    logic [DATA_WIDTH-1:0] addr_dm_i;
    logic [DATA_WIDTH-1:0] wdata_dm_i;
    logic                  w_en_dm_i;
    logic                  valid_dm_rsp_o;
    logic                  ready_dm_rsp_i;
    logic [DATA_WIDTH-1:0] rdata_dm_o;

    // Shared memory port
    logic                  valid_mem_o;
    logic                  ready_mem_i;
    logic [DATA_WIDTH-1:0] addr_mem_o;
    logic [DATA_WIDTH-1:0] wdata_mem_o;
    logic                  w_en_mem_o;
    logic                  valid_mem_rsp_i;
    logic                  ready_mem_rsp_o;
    logic [DATA_WIDTH-1:0] rdata_mem_i;

    modport slave (
        input  valid_if_i, addr_if_i, ready_if_rsp_i,
        input  valid_dm_i, addr_dm_i, wdata_dm_i, w_en_dm_i, ready_dm_rsp_i,
        input  ready_mem_i, valid_mem_rsp_i, rdata_mem_i,
        output ready_if_o, valid_if_rsp_o, rdata_if_o,
        output ready_dm_o, valid_dm_rsp_o, rdata_dm_o,
        output valid_mem_o, addr_mem_o, wdata_mem_o, w_en_mem_o, ready_mem_rsp_o
    );

    modport master (
        output valid_if_i, addr_if_i, ready_if_rsp_i,
        output valid_dm_i, addr_dm_i, wdata_dm_i, w_en_dm_i, ready_dm_rsp_i,
        output ready_mem_i, valid_mem_rsp_i, rdata_mem_i,
        input  ready_if_o, valid_if_rsp_o, rdata_if_o,
        input  ready_dm_o, valid_dm_rsp_o, rdata_dm_o,
        input  valid_mem_o, addr_mem_o, wdata_mem_o, w_en_mem_o, ready_mem_rsp_o
    );

endinterface : cprv_dmem_arbiter_if

// File: rtl/cprv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// cprv_dmem_arbiter
//   Shares one memory port between the fetch stage and the mem stage with
//   exactly one transaction outstanding. FSM: IDLE -> ISSUE -> WAIT_RSP.
//   A requester is granted in IDLE (its ready pulses combinationally), its
//   request fields are latched, the request is presented to memory in ISSUE
//   until accepted, and the response is routed back to the owner in WAIT_RSP.
//
//   Ports:
//     clk - single clock, all state changes on posedge
//     rst - synchronous, active-high reset; all valid/ready outputs are held
//           low while it is asserted, and any in-flight transaction is dropped
//     bus - cprv_dmem_arbiter_if.slave (fetch, mem-stage and memory ports)
//
//   Parameter:
//     DATA_WIDTH - address/data width; must match the interface instance
//
//   Build option:
//     CPRV_DMEM_ARB_RR_EN - when defined, simultaneous requests are granted
//     round-robin (the requester not granted last wins). When undefined, the
//     mem stage always wins a tie and no last-grant state exists.
// -----------------------------------------------------------------------------
module cprv_dmem_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    cprv_dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [DATA_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  w_en_q,  w_en_d;

    logic                  grant_if;
    logic                  grant_dm;
    logic                  rsp_hs;

    // Grants only exist in IDLE and never while reset is asserted, so the
    // ready outputs can be driven straight from them.
    logic                  can_grant;
    assign can_grant = (state_q == S_IDLE) && !rst;

`ifdef CPRV_DMEM_ARB_RR_EN
    owner_e last_q, last_d;

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        last_d   = last_q;
        if (can_grant) begin
            if (bus.valid_dm_i && bus.valid_if_i) begin
                // Tie: the requester that did not win last time goes first.
                grant_dm = (last_q == OWN_IF);
                grant_if = (last_q == OWN_DM);
            end else begin
                grant_dm = bus.valid_dm_i;
                grant_if = bus.valid_if_i;
            end
        end
        if (grant_dm) begin
            last_d = OWN_DM;
        end else if (grant_if) begin
            last_d = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: the mem stage always wins a tie.
    always_comb begin
        grant_dm = can_grant && bus.valid_dm_i;
        grant_if = can_grant && bus.valid_if_i && !bus.valid_dm_i;
    end
`endif

    // Response handshake as seen on the memory side.
    assign rsp_hs = bus.valid_mem_rsp_i && bus.ready_mem_rsp_o;

    // -------------------------------------------------------------------------
    // State register and latched request fields
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            // NOTE: these wide datapath registers are reset only because they
            // are directly visible on addr/wdata_mem_o; pure storage that is
            // always written before being read would normally skip reset.
            addr_q  <= '0;
            wdata_q <= '0;
            w_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            w_en_q  <= w_en_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        w_en_d  = w_en_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_dm) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_DM;
                    addr_d  = bus.addr_dm_i;
                    wdata_d = bus.wdata_dm_i;
                    w_en_d  = bus.w_en_dm_i;
                end else if (grant_if) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_IF;
                    addr_d  = bus.addr_if_i;
                    wdata_d = '0;
                    w_en_d  = 1'b0;          // fetch is always a read
                end
            end
            S_ISSUE: begin
                if (bus.ready_mem_i) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.ready_if_o      = grant_if;
        bus.ready_dm_o      = grant_dm;

        bus.valid_mem_o     = (state_q == S_ISSUE) && !rst;
        bus.addr_mem_o      = addr_q;
        bus.wdata_mem_o     = wdata_q;
        bus.w_en_mem_o      = w_en_q;

        bus.valid_if_rsp_o  = 1'b0;
        bus.valid_dm_rsp_o  = 1'b0;
        bus.ready_mem_rsp_o = 1'b0;
        // Outside WAIT_RSP the memory response is refused, so a response that
        // arrives after a reset abandoned its transaction is simply dropped.
        if ((state_q == S_WAIT_RSP) && !rst) begin
            if (owner_q == OWN_DM) begin
                bus.valid_dm_rsp_o  = bus.valid_mem_rsp_i;
                bus.ready_mem_rsp_o = bus.ready_dm_rsp_i;
            end else begin
                bus.valid_if_rsp_o  = bus.valid_mem_rsp_i;
                bus.ready_mem_rsp_o = bus.ready_if_rsp_i;
            end
        end

        // Read data is broadcast; consumers qualify it with their valid.
        bus.rdata_if_o      = bus.rdata_mem_i;
        bus.rdata_dm_o      = bus.rdata_mem_i;
    end

endmodule : cprv_dmem_arbiter

// File: tb/tb_cprv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cprv_dmem_arbiter
//   Self-checking bench for cprv_dmem_arbiter. Each expected transaction
//   (winner, request fields, response data) is queued when its requests are
//   driven and popped when the arbiter grants, then followed through the
//   ISSUE and WAIT_RSP phases cycle by cycle. Build with
//   +define+CPRV_DMEM_ARB_RR_EN to check the round-robin variant.
// -----------------------------------------------------------------------------
module tb_cprv_dmem_arbiter;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cprv_dmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    cprv_dmem_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          is_dm;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          w_en;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_dm, input logic [DW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic w_en,
                                input logic [DW-1:0] rdata);
        exp_t e;
        e.is_dm = is_dm;
        e.addr  = addr;
        e.wdata = wdata;
        e.w_en  = w_en;
        e.rdata = rdata;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_handshakes_low(input string tag);
        check({tag, "_ready_if"},     bus.ready_if_o,      1'b0);
        check({tag, "_ready_dm"},     bus.ready_dm_o,      1'b0);
        check({tag, "_valid_mem"},    bus.valid_mem_o,     1'b0);
        check({tag, "_valid_if_rsp"}, bus.valid_if_rsp_o,  1'b0);
        check({tag, "_valid_dm_rsp"}, bus.valid_dm_rsp_o,  1'b0);
        check({tag, "_ready_mem_rsp"},bus.ready_mem_rsp_o, 1'b0);
    endtask

    // IDLE cycle with requests driven: the oldest expectation names the winner.
    task automatic grant_phase(output exp_t e);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
            e = mk(1'b0, '0, '0, 1'b0, '0);
        end else begin
            e = sb.pop_front();
        end
        check("grant_ready_dm",  bus.ready_dm_o,  e.is_dm);
        check("grant_ready_if",  bus.ready_if_o,  !e.is_dm);
        check("grant_valid_mem", bus.valid_mem_o, 1'b0);
        tick();
    endtask

    // ISSUE: memory refuses for 'stall' cycles, then accepts.
    task automatic issue_phase(input exp_t e, input int stall);
        for (int i = 0; i <= stall; i++) begin
            bus.ready_mem_i = (i == stall);
            #1;
            check("issue_valid_mem", bus.valid_mem_o, 1'b1);
            check("issue_addr_mem",  bus.addr_mem_o,  e.addr);
            check("issue_w_en_mem",  bus.w_en_mem_o,  e.w_en);
            if (e.w_en) check("issue_wdata_mem", bus.wdata_mem_o, e.wdata);
            check("issue_ready_if",  bus.ready_if_o,  1'b0);
            check("issue_ready_dm",  bus.ready_dm_o,  1'b0);
            tick();
        end
        bus.ready_mem_i = 1'b0;
        #1;
        check("wait_valid_mem", bus.valid_mem_o, 1'b0);
    endtask

    // WAIT_RSP: memory responds, owner refuses for 'rsp_stall' cycles.
    // The non-owner's response ready is held high throughout so any
    // misrouting shows up on ready_mem_rsp_o.
    task automatic rsp_phase(input exp_t e, input int rsp_stall);
        bus.valid_mem_rsp_i = 1'b1;
        bus.rdata_mem_i     = e.rdata;
        for (int i = 0; i <= rsp_stall; i++) begin
            if (e.is_dm) begin
                bus.ready_dm_rsp_i = (i == rsp_stall);
                bus.ready_if_rsp_i = 1'b1;
            end else begin
                bus.ready_if_rsp_i = (i == rsp_stall);
                bus.ready_dm_rsp_i = 1'b1;
            end
            #1;
            check("rsp_valid_dm",  bus.valid_dm_rsp_o,  e.is_dm);
            check("rsp_valid_if",  bus.valid_if_rsp_o,  !e.is_dm);
            check("rsp_ready_mem", bus.ready_mem_rsp_o, (i == rsp_stall));
            check("rsp_rdata_if",  bus.rdata_if_o,      e.rdata);
            check("rsp_rdata_dm",  bus.rdata_dm_o,      e.rdata);
            check("rsp_ready_if",  bus.ready_if_o,      1'b0);
            check("rsp_ready_dm",  bus.ready_dm_o,      1'b0);
            tick();
        end
        bus.valid_mem_rsp_i = 1'b0;
        bus.ready_if_rsp_i  = 1'b0;
        bus.ready_dm_rsp_i  = 1'b0;
        #1;
        check("idle_valid_dm_rsp", bus.valid_dm_rsp_o,  1'b0);
        check("idle_valid_if_rsp", bus.valid_if_rsp_o,  1'b0);
        check("idle_ready_mem_rsp",bus.ready_mem_rsp_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [DW-1:0] rd;

        bus.valid_if_i      = 1'b0;
        bus.addr_if_i       = '0;
        bus.ready_if_rsp_i  = 1'b0;
        bus.valid_dm_i      = 1'b0;
        bus.addr_dm_i       = '0;
        bus.wdata_dm_i      = '0;
        bus.w_en_dm_i       = 1'b0;
        bus.ready_dm_rsp_i  = 1'b0;
        bus.ready_mem_i     = 1'b0;
        bus.valid_mem_rsp_i = 1'b0;
        bus.rdata_mem_i     = '0;

        // ---- Reset: everything quiet even with all inputs pushing ----------
        rst = 1'b1;
        tick();
        bus.valid_if_i      = 1'b1;
        bus.valid_dm_i      = 1'b1;
        bus.valid_mem_rsp_i = 1'b1;
        bus.ready_if_rsp_i  = 1'b1;
        bus.ready_dm_rsp_i  = 1'b1;
        #1;
        check_all_handshakes_low("rst");
        check("rst_addr_mem",  bus.addr_mem_o,  '0);
        check("rst_wdata_mem", bus.wdata_mem_o, '0);
        check("rst_w_en_mem",  bus.w_en_mem_o,  1'b0);
        tick();
        bus.valid_if_i      = 1'b0;
        bus.valid_dm_i      = 1'b0;
        bus.valid_mem_rsp_i = 1'b0;
        bus.ready_if_rsp_i  = 1'b0;
        bus.ready_dm_rsp_i  = 1'b0;
        rst = 1'b0;
        tick();
        check_all_handshakes_low("idle");

        // ---- Fetch only, immediate memory accept ----------------------------
        bus.valid_if_i = 1'b1;
        bus.addr_if_i  = 64'h1000;
        sb.push_back(mk(1'b0, 64'h1000, '0, 1'b0, 64'hDEAD));
        grant_phase(e);
        bus.valid_if_i = 1'b0;
        issue_phase(e, 0);
        rsp_phase(e, 0);
        check_all_handshakes_low("after_fetch");

        // ---- Store with 3 stall cycles; inputs scrambled after grant --------
        bus.valid_dm_i = 1'b1;
        bus.addr_dm_i  = 64'h2008;
        bus.wdata_dm_i = 64'h55;
        bus.w_en_dm_i  = 1'b1;
        sb.push_back(mk(1'b1, 64'h2008, 64'h55, 1'b1, {$urandom, $urandom}));
        grant_phase(e);
        bus.valid_dm_i = 1'b0;
        bus.addr_dm_i  = 64'hFFFF_0000_BAD0_0000;
        bus.wdata_dm_i = 64'hA5A5_A5A5_A5A5_A5A5;
        bus.w_en_dm_i  = 1'b0;
        issue_phase(e, 3);
        rsp_phase(e, 0);

        // ---- Load with response backpressure; fetch waits behind it ---------
        bus.valid_dm_i = 1'b1;
        bus.addr_dm_i  = 64'h3000;
        sb.push_back(mk(1'b1, 64'h3000, '0, 1'b0, {$urandom, $urandom}));
        grant_phase(e);
        bus.valid_dm_i = 1'b0;
        bus.valid_if_i = 1'b1;
        bus.addr_if_i  = 64'h1040;
        issue_phase(e, 1);
        rsp_phase(e, 2);
        sb.push_back(mk(1'b0, 64'h1040, '0, 1'b0, {$urandom, $urandom}));
        grant_phase(e);
        bus.valid_if_i = 1'b0;
        issue_phase(e, 0);
        rsp_phase(e, 0);

        // ---- Both requesters valid for 4 back-to-back transactions ----------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.valid_if_i = 1'b1;
        bus.addr_if_i  = 64'h4000;
        bus.valid_dm_i = 1'b1;
        bus.addr_dm_i  = 64'h5000;
        bus.w_en_dm_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef CPRV_DMEM_ARB_RR_EN
            if (i % 2 == 0) sb.push_back(mk(1'b1, 64'h5000, '0, 1'b0, {$urandom, $urandom}));
            else            sb.push_back(mk(1'b0, 64'h4000, '0, 1'b0, {$urandom, $urandom}));
`else
            sb.push_back(mk(1'b1, 64'h5000, '0, 1'b0, {$urandom, $urandom}));
`endif
        end
        for (int i = 0; i < 4; i++) begin
            grant_phase(e);
            issue_phase(e, 0);
            rsp_phase(e, 0);
        end
        bus.valid_if_i = 1'b0;
        bus.valid_dm_i = 1'b0;

        // ---- Reset during WAIT_RSP, late response must be ignored -----------
        bus.valid_dm_i = 1'b1;
        bus.addr_dm_i  = 64'h6000;
        sb.push_back(mk(1'b1, 64'h6000, '0, 1'b0, {$urandom, $urandom}));
        grant_phase(e);
        bus.valid_dm_i = 1'b0;
        issue_phase(e, 0);
        rst = 1'b1;
        bus.valid_mem_rsp_i = 1'b1;
        bus.ready_dm_rsp_i  = 1'b1;
        bus.ready_if_rsp_i  = 1'b1;
        #1;
        check_all_handshakes_low("rst_wait");
        tick();
        rst = 1'b0;
        #1;
        check_all_handshakes_low("late_rsp0");
        tick();
        check_all_handshakes_low("late_rsp1");
        bus.valid_mem_rsp_i = 1'b0;
        bus.ready_dm_rsp_i  = 1'b0;
        bus.ready_if_rsp_i  = 1'b0;

        // After reset a tie goes to the mem stage in either build.
        rd = {$urandom, $urandom};
        bus.valid_if_i = 1'b1;
        bus.addr_if_i  = 64'h7000;
        bus.valid_dm_i = 1'b1;
        bus.addr_dm_i  = 64'h7800;
        sb.push_back(mk(1'b1, 64'h7800, '0, 1'b0, rd));
        grant_phase(e);
        bus.valid_if_i = 1'b0;
        bus.valid_dm_i = 1'b0;
        issue_phase(e, 0);
        rsp_phase(e, 0);

        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cprv_dmem_arbiter
